// File: rtl/bus_defs.sv
// Shared definitions for the memory bus responder: bus width, wait-state limit and FSM encoding.
package bus_defs;

   localparam int unsigned BUS_W    = 16;
   localparam int unsigned MAX_WAIT = 15;
   localparam int unsigned WAIT_W   = $clog2(MAX_WAIT + 1);

   typedef enum logic [2:0] {
      IDLE,
      ADDR,
      WAIT,
      ACCESS,
      DONE
   } resp_state_t;

endpackage

// File: rtl/resp_ram.sv
// Single-port synchronous RAM with registered read data.
// Kept standalone so a compiled memory macro can be dropped in.
module resp_ram
   import bus_defs::*;
#(
   parameter int unsigned DEPTH_LOG2 = 10
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [DEPTH_LOG2-1:0] addr,
   input  logic [BUS_W-1:0]      wdata,
   output logic [BUS_W-1:0]      rdata
);

   logic [BUS_W-1:0] mem [2**DEPTH_LOG2];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
      rdata <= mem[addr];
   end

endmodule

// File: rtl/mem_bus_responder.sv
// Target side of the core's multiplexed 16-bit memory bus: address latch, window decode,
// programmable wait states, and read/write service into a local RAM.
module mem_bus_responder
   import bus_defs::*;
#(
   parameter logic [BUS_W-1:0] ADDR_BASE   = 16'h0000,
   parameter int unsigned      DEPTH_LOG2  = 10,
   parameter int unsigned      WAIT_STATES = 2
) (
   input  logic             Clock,
   input  logic             nReset,
   input  logic [BUS_W-1:0] BusIn,
   input  logic             ALE,
   input  logic             nME,
   input  logic             nOE,
   input  logic             RnW,
   output logic [BUS_W-1:0] DataOut,
   output logic             DataOutEn,
   output logic             nWait
);

   localparam logic [BUS_W:0] WIN_SIZE = (BUS_W + 1)'(2**DEPTH_LOG2);

   resp_state_t       state;
   logic [BUS_W-1:0]  addr_q;
   logic [WAIT_W-1:0] wait_cnt;
   logic              last_read;
   logic [BUS_W-1:0]  ram_rdata;

   logic [BUS_W-1:0]  offset_c;
   logic              in_window_c;
   logic              ram_we_c;

   // Window compare is done one bit wider so the top of the address space never wraps.
   assign offset_c    = addr_q - ADDR_BASE;
   assign in_window_c = (addr_q >= ADDR_BASE) && ({1'b0, offset_c} < WIN_SIZE);
   // An ALE or a released nME in the ACCESS cycle cancels the write.
   assign ram_we_c    = (state == ACCESS) && !ALE && !nME && !RnW;

   resp_ram #(
      .DEPTH_LOG2(DEPTH_LOG2)
   ) u_ram (
      .clk   (Clock),
      .we    (ram_we_c),
      .addr  (offset_c[DEPTH_LOG2-1:0]),
      .wdata (BusIn),
      .rdata (ram_rdata)
   );

   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         state     <= IDLE;
         addr_q    <= '0;
         wait_cnt  <= '0;
         last_read <= 1'b0;
         DataOut   <= '0;
         DataOutEn <= 1'b0;
         nWait     <= 1'b1;
      end else if (ALE && (state != IDLE)) begin
         addr_q    <= BusIn;
         state     <= ADDR;
         nWait     <= 1'b1;
         DataOutEn <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (ALE) begin
                  addr_q <= BusIn;
                  state  <= ADDR;
               end
            end
            ADDR: begin
               if (!nME) begin
                  last_read <= 1'b0;
                  if (in_window_c) begin
                     wait_cnt <= WAIT_W'(WAIT_STATES);
                     if (WAIT_STATES > 0) begin
                        state <= WAIT;
                        nWait <= 1'b0;
                     end else begin
                        state <= ACCESS;
                     end
                  end else begin
                     state <= DONE;
                  end
               end
            end
            WAIT: begin
               if (nME) begin
                  state <= IDLE;
                  nWait <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt - 1'b1;
                  if (wait_cnt == WAIT_W'(1)) begin
                     nWait <= 1'b1;
                     state <= ACCESS;
                  end
               end
            end
            ACCESS: begin
               if (nME) begin
                  state <= IDLE;
               end else begin
                  last_read <= RnW;
                  if (RnW) begin
                     DataOut <= ram_rdata;
                  end
                  state <= DONE;
               end
            end
            DONE: begin
               if (nME) begin
                  DataOutEn <= 1'b0;
                  state     <= IDLE;
               end else begin
                  DataOutEn <= last_read & ~nOE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_bus_responder.sv
// Directed bench for mem_bus_responder: one instance with two wait states, one with none.
module tb_mem_bus_responder;

   logic        Clock;
   logic        nReset;
   logic        ale   [2];
   logic        nme   [2];
   logic        noe   [2];
   logic        rnw   [2];
   logic [15:0] bus   [2];
   logic [15:0] dout  [2];
   logic        den   [2];
   logic        nwait [2];

   int checks = 0;
   int passes = 0;
   int b_lows = 0;
   int lows;

   mem_bus_responder #(.ADDR_BASE(16'h0000), .DEPTH_LOG2(10), .WAIT_STATES(2)) dut_a (
      .Clock(Clock), .nReset(nReset), .BusIn(bus[0]), .ALE(ale[0]), .nME(nme[0]),
      .nOE(noe[0]), .RnW(rnw[0]), .DataOut(dout[0]), .DataOutEn(den[0]), .nWait(nwait[0])
   );

   mem_bus_responder #(.ADDR_BASE(16'h0000), .DEPTH_LOG2(10), .WAIT_STATES(0)) dut_b (
      .Clock(Clock), .nReset(nReset), .BusIn(bus[1]), .ALE(ale[1]), .nME(nme[1]),
      .nOE(noe[1]), .RnW(rnw[1]), .DataOut(dout[1]), .DataOutEn(den[1]), .nWait(nwait[1])
   );

   always #5 Clock = ~Clock;

   // The zero-wait instance must never stall.
   always @(negedge Clock) begin
      if (nwait[1] === 1'b0) b_lows++;
   end

   task automatic tick();
      @(posedge Clock);
      @(negedge Clock);
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic addr_phase(input int d, input logic [15:0] a);
      ale[d] = 1'b1;
      bus[d] = a;
      tick();
      ale[d] = 1'b0;
   endtask

   // Full access: address, nME low for ws+2 edges, then nOE pulse and release.
   task automatic run_access(input int d, input int ws, input logic rd, input logic [15:0] a,
                             input logic [15:0] data, input string tag,
                             input logic early, input logic [15:0] early_exp);
      int n = 0;
      addr_phase(d, a);
      rnw[d] = rd;
      bus[d] = rd ? 16'h0000 : data;
      nme[d] = 1'b0;
      noe[d] = 1'b1;
      for (int i = 0; i < ws + 2; i++) begin
         tick();
         if (nwait[d] === 1'b0) n++;
         if (early && (i == ws)) chk({tag, "_early"}, dout[d], early_exp);
      end
      chk({tag, "_nwait_lows"}, 16'(n), 16'(ws));
      if (rd) chk({tag, "_data"}, dout[d], data);
      chk({tag, "_en_noe_hi"}, 16'(den[d]), 16'h0000);
      noe[d] = 1'b0;
      tick();
      chk({tag, "_en_noe_lo"}, 16'(den[d]), 16'(rd));
      noe[d] = 1'b1;
      tick();
      chk({tag, "_en_noe_off"}, 16'(den[d]), 16'h0000);
      nme[d] = 1'b1;
      tick();
      chk({tag, "_idle_nwait"}, 16'(nwait[d]), 16'h0001);
   endtask

   initial begin
      Clock  = 1'b0;
      nReset = 1'b0;
      for (int d = 0; d < 2; d++) begin
         ale[d] = 1'b0; nme[d] = 1'b1; noe[d] = 1'b1; rnw[d] = 1'b1; bus[d] = 16'h0000;
      end
      #12;
      for (int d = 0; d < 2; d++) begin
         chk("rst_dout", dout[d], 16'h0000);
         chk("rst_en", 16'(den[d]), 16'h0000);
         chk("rst_nwait", 16'(nwait[d]), 16'h0001);
      end
      @(negedge Clock);
      nReset = 1'b1;
      tick();

      // Write then read with two wait states; data lands on the 4th edge after nME.
      run_access(0, 2, 1'b0, 16'h0005, 16'hBEEF, "t1_wr", 1'b0, 16'h0000);
      run_access(0, 2, 1'b1, 16'h0005, 16'hBEEF, "t1_rd", 1'b1, 16'h0000);

      // Zero wait states, back-to-back reads with the second address latched from DONE.
      run_access(1, 0, 1'b0, 16'h0000, 16'hA5A5, "t2_wr0", 1'b0, 16'h0000);
      run_access(1, 0, 1'b0, 16'h03FF, 16'h5A5A, "t2_wr1", 1'b0, 16'h0000);
      addr_phase(1, 16'h0000);
      rnw[1] = 1'b1; nme[1] = 1'b0;
      tick(); tick();
      chk("t2_rd0", dout[1], 16'hA5A5);
      ale[1] = 1'b1; bus[1] = 16'h03FF;
      tick();
      ale[1] = 1'b0;
      tick(); tick();
      chk("t2_rd1", dout[1], 16'h5A5A);
      noe[1] = 1'b0;
      tick();
      chk("t2_en", 16'(den[1]), 16'h0001);
      noe[1] = 1'b1; nme[1] = 1'b1;
      tick();
      chk("t2_no_stall", 16'(b_lows), 16'h0000);

      // Out-of-window write must not alias onto index 0.
      run_access(0, 2, 1'b0, 16'h0000, 16'h1111, "t3_pre", 1'b0, 16'h0000);
      addr_phase(0, 16'h0400);
      rnw[0] = 1'b0; bus[0] = 16'hDEAD; nme[0] = 1'b0; noe[0] = 1'b0;
      tick();
      chk("t3_nwait_a", 16'(nwait[0]), 16'h0001);
      tick();
      chk("t3_nwait_b", 16'(nwait[0]), 16'h0001);
      chk("t3_en", 16'(den[0]), 16'h0000);
      nme[0] = 1'b1; noe[0] = 1'b1;
      tick();
      run_access(0, 2, 1'b1, 16'h0000, 16'h1111, "t3_rd", 1'b0, 16'h0000);

      // Write aborted by nME release in the second wait cycle.
      run_access(0, 2, 1'b0, 16'h0010, 16'h7777, "t4_pre", 1'b0, 16'h0000);
      addr_phase(0, 16'h0010);
      rnw[0] = 1'b0; bus[0] = 16'h9999; nme[0] = 1'b0;
      tick();
      chk("t4_wait1", 16'(nwait[0]), 16'h0000);
      tick();
      chk("t4_wait2", 16'(nwait[0]), 16'h0000);
      nme[0] = 1'b1;
      tick();
      chk("t4_abort_nwait", 16'(nwait[0]), 16'h0001);
      chk("t4_abort_en", 16'(den[0]), 16'h0000);
      run_access(0, 2, 1'b1, 16'h0010, 16'h7777, "t4_rd", 1'b0, 16'h0000);

      // Reset pulse during a write's wait phase.
      addr_phase(0, 16'h0005);
      rnw[0] = 1'b0; bus[0] = 16'h0BAD; nme[0] = 1'b0;
      tick();
      chk("t5_in_wait", 16'(nwait[0]), 16'h0000);
      #2 nReset = 1'b0;
      #1;
      chk("t5_rst_nwait", 16'(nwait[0]), 16'h0001);
      chk("t5_rst_en", 16'(den[0]), 16'h0000);
      chk("t5_rst_dout", dout[0], 16'h0000);
      #1 nReset = 1'b1;
      nme[0] = 1'b1;
      @(negedge Clock);
      run_access(0, 2, 1'b1, 16'h0005, 16'hBEEF, "t5_rd", 1'b0, 16'h0000);

      // ALE while in DONE drops the old access and starts a new one.
      run_access(0, 2, 1'b0, 16'h0020, 16'h2020, "t6_pre", 1'b0, 16'h0000);
      addr_phase(0, 16'h0005);
      rnw[0] = 1'b1; nme[0] = 1'b0;
      tick(); tick(); tick(); tick();
      chk("t6_old_data", dout[0], 16'hBEEF);
      noe[0] = 1'b0;
      tick();
      chk("t6_old_en", 16'(den[0]), 16'h0001);
      ale[0] = 1'b1; bus[0] = 16'h0020;
      tick();
      chk("t6_ale_en", 16'(den[0]), 16'h0000);
      ale[0] = 1'b0; noe[0] = 1'b1;
      lows = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (nwait[0] === 1'b0) lows++;
      end
      chk("t6_nwait_lows", 16'(lows), 16'h0002);
      chk("t6_new_data", dout[0], 16'h2020);
      noe[0] = 1'b0;
      tick();
      chk("t6_new_en", 16'(den[0]), 16'h0001);
      noe[0] = 1'b1; nme[0] = 1'b1;
      tick();
      chk("t6_idle_en", 16'(den[0]), 16'h0000);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
